// File: rtl/test_pattern_gen_param.sv
// Test-image generator for panel bring-up: border, bars, grey ramp, checker, bouncing box.
// Latency: 1 cycle from (x, y, DE) sampled to R/G/B/DE_out registered.
// Backpressure: none; one pixel per clock whenever DE is high, the panel path never stalls.
module test_pattern_gen_param #(
   parameter int COLOR_BITS    = 8,
   parameter int COORD_BITS    = 12,
   parameter int CHECKER_SHIFT = 5,
   parameter int BOX_SIZE      = 32
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [2:0]            Mode,
   input  logic                  FrameStart,
   input  logic [COORD_BITS-1:0] x,
   input  logic [COORD_BITS-1:0] y,
   input  logic [COORD_BITS-1:0] width,
   input  logic [COORD_BITS-1:0] height,
   input  logic                  DE,
   output logic [COLOR_BITS-1:0] R,
   output logic [COLOR_BITS-1:0] G,
   output logic [COLOR_BITS-1:0] B,
   output logic                  DE_out,
   output logic [15:0]           FrameCount
);

   // One extra bit on remainders so rem + step never overflows before the compare.
   localparam int RW      = COORD_BITS + 1;
   localparam int RAMP_IW = COLOR_BITS + 1;
   localparam logic [RW-1:0]         BAR_STEP  = RW'(8);
   localparam logic [RW-1:0]         RAMP_STEP = RW'(2 ** COLOR_BITS);
   localparam logic [RW-1:0]         BOX_EXT   = RW'(BOX_SIZE);
   localparam logic [COORD_BITS-1:0] BOX_C     = COORD_BITS'(BOX_SIZE);
   localparam logic [COORD_BITS-1:0] ONE       = COORD_BITS'(1);
   localparam logic [COLOR_BITS-1:0] FULL      = '1;

   // Bar colour order differs from a plain {R,G,B} binary count; this maps index -> {r,g,b}.
   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      logic [2:0] c;
      case (idx)
         3'd0:    c = 3'b000; // black
         3'd1:    c = 3'b001; // blue
         3'd2:    c = 3'b010; // green
         3'd3:    c = 3'b100; // red
         3'd4:    c = 3'b101; // magenta
         3'd5:    c = 3'b011; // cyan
         3'd6:    c = 3'b110; // yellow
         default: c = 3'b111; // white
      endcase
      return c;
   endfunction

   logic [2:0]            active_mode;
   logic [COORD_BITS-1:0] box_x, box_y;
   logic                  dir_x_neg, dir_y_neg;
   logic                  de_prev;

   logic [RW-1:0]         bar_rem, ramp_rem, v_rem;
   logic [2:0]            bar_idx, v_idx;
   logic [RAMP_IW-1:0]    ramp_idx;

   logic [RW-1:0]         width_x, height_x;
   logic [RW-1:0]         bar_sum, ramp_sum, v_sum;
   logic [COORD_BITS-1:0] x_lim, y_lim;

   assign width_x  = {1'b0, width};
   assign height_x = {1'b0, height};
   assign bar_sum  = bar_rem + BAR_STEP;
   assign ramp_sum = ramp_rem + RAMP_STEP;
   assign v_sum    = v_rem + BAR_STEP;
   assign x_lim    = width - BOX_C;
   assign y_lim    = height - BOX_C;

   // Horizontal accumulators: idx = floor(x*N/width) built incrementally along the active run.
   always_ff @(posedge Clock) begin
      if (Reset || !DE) begin
         bar_rem  <= '0;
         bar_idx  <= '0;
         ramp_rem <= '0;
         ramp_idx <= '0;
      end else begin
         if (bar_sum >= width_x) begin
            bar_rem <= bar_sum - width_x;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_rem <= bar_sum;
         end
         if (ramp_sum >= width_x) begin
            ramp_rem <= ramp_sum - width_x;
            ramp_idx <= ramp_idx + RAMP_IW'(1);
         end else begin
            ramp_rem <= ramp_sum;
         end
      end
   end

   // Vertical accumulator: steps once per line on the falling edge of DE.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         de_prev <= 1'b0;
         v_rem   <= '0;
         v_idx   <= '0;
      end else begin
         de_prev <= DE;
         if (FrameStart) begin
            v_rem <= '0;
            v_idx <= '0;
         end else if (de_prev && !DE) begin
            if (v_sum >= height_x) begin
               v_rem <= v_sum - height_x;
               v_idx <= v_idx + 3'd1;
            end else begin
               v_rem <= v_sum;
            end
         end
      end
   end

   // Per-frame state: mode latch, frame counter and bouncing-box motion.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         active_mode <= 3'd0;
         FrameCount  <= 16'd0;
         box_x       <= '0;
         box_y       <= '0;
         dir_x_neg   <= 1'b0;
         dir_y_neg   <= 1'b0;
      end else if (FrameStart) begin
         active_mode <= Mode;
         FrameCount  <= FrameCount + 16'd1;
         if (!dir_x_neg) begin
            if (box_x == x_lim) begin
               dir_x_neg <= 1'b1;
               box_x     <= box_x - ONE;
            end else begin
               box_x <= box_x + ONE;
            end
         end else if (box_x == '0) begin
            dir_x_neg <= 1'b0;
            box_x     <= ONE;
         end else begin
            box_x <= box_x - ONE;
         end
         if (!dir_y_neg) begin
            if (box_y == y_lim) begin
               dir_y_neg <= 1'b1;
               box_y     <= box_y - ONE;
            end else begin
               box_y <= box_y + ONE;
            end
         end else if (box_y == '0) begin
            dir_y_neg <= 1'b0;
            box_y     <= ONE;
         end else begin
            box_y <= box_y - ONE;
         end
      end
   end

   logic [2:0]            rgb;
   logic                  use_grey;
   logic [COLOR_BITS-1:0] grey;
   logic                  in_box;

   assign in_box = ({1'b0, x} >= {1'b0, box_x}) && ({1'b0, x} < ({1'b0, box_x} + BOX_EXT)) &&
                   ({1'b0, y} >= {1'b0, box_y}) && ({1'b0, y} < ({1'b0, box_y} + BOX_EXT));

   // Pattern select: on/off per channel for the flat-colour modes, level for the ramp.
   always_comb begin
      rgb      = 3'b000;
      use_grey = 1'b0;
      grey     = ramp_idx[COLOR_BITS] ? FULL : ramp_idx[COLOR_BITS-1:0];
      case (active_mode)
         3'd0: if (x == '0 || x == width - ONE || y == '0 || y == height - ONE) rgb = 3'b111;
         3'd1: rgb = bar_rgb(bar_idx);
         3'd2: rgb = bar_rgb(v_idx);
         3'd3: use_grey = 1'b1;
         3'd4: if (x[CHECKER_SHIFT] ^ y[CHECKER_SHIFT] ^ FrameCount[6]) rgb = 3'b111;
         3'd5: if (in_box) rgb = 3'b111;
         default: rgb = 3'b000;
      endcase
   end

   // Output register: blank whenever DE is low so blanking intervals are black.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         R      <= '0;
         G      <= '0;
         B      <= '0;
         DE_out <= 1'b0;
      end else begin
         DE_out <= DE;
         if (!DE) begin
            R <= '0;
            G <= '0;
            B <= '0;
         end else if (use_grey) begin
            R <= grey;
            G <= grey;
            B <= grey;
         end else begin
            R <= {COLOR_BITS{rgb[2]}};
            G <= {COLOR_BITS{rgb[1]}};
            B <= {COLOR_BITS{rgb[0]}};
         end
      end
   end

endmodule

// File: tb/tb_test_pattern_gen_param.sv
// Bench for test_pattern_gen_param at 800x600 with default parameters.
// Reference model works from pixel coordinates and frame counts with plain arithmetic.
// Checks every output cycle plus literal spot values from the bring-up scenarios.
module tb_test_pattern_gen_param;

   localparam int W = 800;
   localparam int H = 600;
   localparam logic [23:0] WHITE = 24'hFFFFFF;

   logic        Clock;
   logic        Reset;
   logic [2:0]  Mode;
   logic        FrameStart;
   logic [11:0] x, y;
   logic [11:0] width, height;
   logic        DE;
   logic [7:0]  R, G, B;
   logic        DE_out;
   logic [15:0] FrameCount;

   test_pattern_gen_param dut (
      .Clock(Clock), .Reset(Reset), .Mode(Mode), .FrameStart(FrameStart),
      .x(x), .y(y), .width(width), .height(height), .DE(DE),
      .R(R), .G(G), .B(B), .DE_out(DE_out), .FrameCount(FrameCount)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int m_mode  = 0;
   int m_fc    = 0;
   int m_nfr   = 0;
   logic [23:0] obs_pix;
   logic [23:0] bar_tab [0:7] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'hFF0000,
                                  24'hFF00FF, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};

   // Triangle-wave position of the box after n frames, bouncing between 0 and lim.
   function automatic int box_pos(input int n, input int lim);
      int p;
      p = n % (2 * lim);
      return (p <= lim) ? p : 2 * lim - p;
   endfunction

   function automatic logic [23:0] model_pix(input int md, input int xi, input int yi,
                                             input int fc, input int bx, input int by);
      int g;
      case (md)
         0: return (xi == 0 || xi == W - 1 || yi == 0 || yi == H - 1) ? WHITE : 24'h0;
         1: return bar_tab[xi * 8 / W];
         2: return bar_tab[yi * 8 / H];
         3: begin
            g = xi * 256 / W;
            if (g > 255) g = 255;
            return {g[7:0], g[7:0], g[7:0]};
         end
         4: return ((((xi >> 5) ^ (yi >> 5) ^ (fc >> 6)) & 1) != 0) ? WHITE : 24'h0;
         5: return (xi >= bx && xi < bx + 32 && yi >= by && yi < by + 32) ? WHITE : 24'h0;
         default: return 24'h0;
      endcase
   endfunction

   task automatic step(input logic rst, input logic fs, input logic de,
                       input int xi, input int yi, input logic [2:0] md);
      logic [23:0] exp_pix;
      logic        exp_de;
      Reset = rst; FrameStart = fs; DE = de; Mode = md;
      x = xi[11:0]; y = yi[11:0];
      if (rst || !de) exp_pix = 24'h0;
      else exp_pix = model_pix(m_mode, xi, yi, m_fc,
                               box_pos(m_nfr, W - 32), box_pos(m_nfr, H - 32));
      exp_de = !rst && de;
      @(posedge Clock);
      #1;
      if (rst) begin
         m_mode = 0; m_fc = 0; m_nfr = 0;
      end else if (fs) begin
         m_mode = int'(md); m_fc = (m_fc + 1) % 65536; m_nfr++;
      end
      obs_pix = {R, G, B};
      n_tests++;
      assert ({obs_pix, DE_out} === {exp_pix, exp_de})
      else begin
         n_fail++;
         $error("FAIL pix x=%0d y=%0d mode=%0d: got %h de=%b, want %h de=%b",
                xi, yi, m_mode, obs_pix, DE_out, exp_pix, exp_de);
      end
      n_tests++;
      assert (FrameCount === 16'(m_fc))
      else begin
         n_fail++;
         $error("FAIL framecount: got %0d, want %0d", FrameCount, m_fc);
      end
   endtask

   task automatic lit(input string tag, input logic [23:0] want);
      n_tests++;
      assert (obs_pix === want)
      else begin
         n_fail++;
         $error("FAIL %s: got %h, want %h", tag, obs_pix, want);
      end
   endtask

   task automatic fstart(input logic [2:0] md);
      step(1'b0, 1'b1, 1'b0, 0, 0, md);
      step(1'b0, 1'b0, 1'b0, 0, 0, md);
   endtask

   task automatic line(input int yi, input int len, input logic [2:0] md);
      for (int i = 0; i < len; i++) step(1'b0, 1'b0, 1'b1, i, yi, md);
      step(1'b0, 1'b0, 1'b0, 0, yi, md);
   endtask

   initial begin
      int nl, len;
      logic [2:0] md, md2;
      Reset = 1'b1; FrameStart = 1'b0; DE = 1'b0; Mode = 3'd0;
      x = '0; y = '0; width = 12'(W); height = 12'(H);

      // Reset state
      step(1'b1, 1'b0, 1'b0, 0, 0, 3'd0);
      step(1'b1, 1'b0, 1'b1, 5, 5, 3'd0);
      lit("reset_out", 24'h0);
      step(1'b0, 1'b0, 1'b0, 0, 0, 3'd0);

      // Grey ramp on line 10
      fstart(3'd3);
      for (int l = 0; l < 10; l++) line(l, 1, 3'd3);
      for (int i = 0; i < W; i++) begin
         step(1'b0, 1'b0, 1'b1, i, 10, 3'd3);
         if (i == 3)   lit("ramp_x3", 24'h000000);
         if (i == 4)   lit("ramp_x4", 24'h010101);
         if (i == 400) lit("ramp_x400", 24'h808080);
         if (i == 799) lit("ramp_x799", 24'hFFFFFF);
      end
      step(1'b0, 1'b0, 1'b0, 0, 10, 3'd3);
      lit("ramp_blank", 24'h0);

      // Vertical bars
      fstart(3'd1);
      for (int i = 0; i < W; i++) begin
         step(1'b0, 1'b0, 1'b1, i, 0, 3'd1);
         if (i == 99)  lit("vbar_x99", 24'h000000);
         if (i == 100) lit("vbar_x100", 24'h0000FF);
         if (i == 300) lit("vbar_x300", 24'hFF0000);
         if (i == 700) lit("vbar_x700", 24'hFFFFFF);
         if (i == 799) lit("vbar_x799", 24'hFFFFFF);
      end
      step(1'b0, 1'b0, 1'b0, 0, 0, 3'd1);
      lit("vbar_blank", 24'h0);

      // Horizontal bars over a whole frame of short lines
      fstart(3'd2);
      for (int l = 0; l < H; l++) begin
         step(1'b0, 1'b0, 1'b1, 0, l, 3'd2);
         if (l == 74)  lit("hbar_y74", 24'h000000);
         if (l == 75)  lit("hbar_y75", 24'h0000FF);
         if (l == 599) lit("hbar_y599", 24'hFFFFFF);
         step(1'b0, 1'b0, 1'b0, 0, l, 3'd2);
      end

      // Border, with Mode switched to bars mid-frame
      fstart(3'd0);
      line(0, W, 3'd0);
      for (int l = 1; l < 5; l++) line(l, 1, 3'd1);
      for (int i = 0; i < W; i++) begin
         step(1'b0, 1'b0, 1'b1, i, 5, 3'd1);
         if (i == 0)   lit("border_x0", WHITE);
         if (i == 1)   lit("border_x1", 24'h0);
         if (i == 400) lit("border_x400", 24'h0);
         if (i == 799) lit("border_x799", WHITE);
      end
      step(1'b0, 1'b0, 1'b0, 0, 5, 3'd1);
      fstart(3'd1);
      for (int i = 0; i < 120; i++) step(1'b0, 1'b0, 1'b1, i, 0, 3'd1);
      lit("bars_after_switch", 24'h0000FF);
      step(1'b0, 1'b0, 1'b0, 0, 0, 3'd1);

      // Bouncing box: x turns at 768, y turns at 568
      step(1'b1, 1'b0, 1'b0, 0, 0, 3'd5);
      for (int f = 0; f < 568; f++) fstart(3'd5);
      for (int i = 0; i < W; i++) begin
         step(1'b0, 1'b0, 1'b1, i, 568, 3'd5);
         if (i == 567) lit("box568_x567", 24'h0);
         if (i == 568) lit("box568_x568", WHITE);
      end
      step(1'b0, 1'b0, 1'b0, 0, 568, 3'd5);
      fstart(3'd5);
      line(567, W, 3'd5);
      line(599, W, 3'd5);
      for (int f = 569; f < 768; f++) fstart(3'd5);
      for (int i = 0; i < W; i++) begin
         step(1'b0, 1'b0, 1'b1, i, 368, 3'd5);
         if (i == 767) lit("box768_x767", 24'h0);
         if (i == 768) lit("box768_x768", WHITE);
      end
      step(1'b0, 1'b0, 1'b0, 0, 368, 3'd5);
      fstart(3'd5);
      for (int i = 0; i < W; i++) begin
         step(1'b0, 1'b0, 1'b1, i, 367, 3'd5);
         if (i == 767) lit("box769_x767", WHITE);
         if (i == 799) lit("box769_x799", 24'h0);
      end
      step(1'b0, 1'b0, 1'b0, 0, 367, 3'd5);

      // Reset mid-line in ramp mode, then border after the next frame start
      fstart(3'd3);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, i, 0, 3'd3);
      step(1'b1, 1'b0, 1'b1, 100, 0, 3'd3);
      lit("midreset_out", 24'h0);
      step(1'b0, 1'b0, 1'b0, 0, 0, 3'd3);
      fstart(3'd0);
      line(0, W, 3'd0);
      line(1, W, 3'd0);

      // Randomised frames: random mode, line count, line length, mid-frame Mode noise
      for (int f = 0; f < 12; f++) begin
         md = 3'($urandom_range(0, 7));
         fstart(md);
         nl = $urandom_range(1, 30);
         for (int l = 0; l < nl; l++) begin
            len = ($urandom_range(0, 7) == 0) ? W : $urandom_range(1, 16);
            md2 = 3'($urandom_range(0, 7));
            line(l, len, md2);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
